// File: rtl/neuron.sv
// neuron: weighted-sum stage feeding the threshold activation unit.
//
// Takes a vector of N unsigned Q0.8 activations and multiply-accumulates it
// against stored signed Q8.8 weights plus a bias, one element per cycle. The
// result is returned as a saturated signed Q8.8 argument. When the vector was
// accepted with train=1, the block then waits for a delta and updates every
// weight and the bias from the stored inputs.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   train                 : mode, sampled only on the input handshake edge
//   input_valid/ready/data: input vector, element i at [8i+7:8i]
//   argument_valid/ready/data : saturated Q8.8 weighted sum
//   delta_valid/ready/data: signed Q8.8 training delta
module neuron #(
   parameter int N    = 4,
   parameter int RATE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             train,
   input  logic             input_valid,
   output logic             input_ready,
   input  logic [8*N-1:0]   input_data,
   output logic             argument_valid,
   input  logic             argument_ready,
   output logic [15:0]      argument_data,
   input  logic             delta_valid,
   output logic             delta_ready,
   input  logic [15:0]      delta_data
);

   // Index must reach N so UPDATE can spend one extra cycle on the bias.
   localparam int IW = $clog2(N + 1);

   typedef enum logic [2:0] {IDLE, MAC, OUT, WAIT, UPDATE} state_e;

   state_e                  state_q, state_d;
   logic [N-1:0][15:0]      w_q, w_d;
   logic signed [15:0]      b_q, b_d;
   logic [N-1:0][7:0]       x_q, x_d;
   logic signed [31:0]      acc_q, acc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    train_q, train_d;
   logic signed [15:0]      delta_q, delta_d;

   logic signed [24:0]      mac_prod;
   logic signed [24:0]      upd_prod;
   logic signed [24:0]      upd_term;
   logic signed [31:0]      w_sum;
   logic signed [31:0]      b_sum;

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)       return 16'h7fff;
      else if (v < -32'sd32768) return 16'h8000;
      else                      return v[15:0];
   endfunction

   // x is zero-extended to 9 bits so the product stays signed.
   always_comb begin
      mac_prod = $signed(w_q[idx_q]) * $signed({1'b0, x_q[idx_q]});
      upd_prod = delta_q * $signed({1'b0, x_q[idx_q]});
      upd_term = upd_prod >>> (8 + RATE);
      w_sum    = 32'($signed(w_q[idx_q])) + 32'(upd_term);
      b_sum    = 32'(b_q) + 32'(delta_q >>> RATE);
   end

   always_comb begin
      state_d        = state_q;
      w_d            = w_q;
      b_d            = b_q;
      x_d            = x_q;
      acc_d          = acc_q;
      idx_d          = idx_q;
      train_d        = train_q;
      delta_d        = delta_q;
      input_ready    = 1'b0;
      argument_valid = 1'b0;
      delta_ready    = 1'b0;
      case (state_q)
         IDLE: begin
            input_ready = 1'b1;
            if (input_valid) begin
               x_d     = input_data;
               train_d = train;
               acc_d   = 32'(b_q) <<< 8;
               idx_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + 32'(mac_prod);
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(N - 1)) state_d = OUT;
         end
         OUT: begin
            argument_valid = 1'b1;
            if (argument_ready) state_d = train_q ? WAIT : IDLE;
         end
         WAIT: begin
            delta_ready = 1'b1;
            if (delta_valid) begin
               delta_d = delta_data;
               idx_d   = '0;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            if (idx_q == IW'(N)) begin
               b_d     = sat16(b_sum);
               state_d = IDLE;
            end else begin
               w_d[idx_q] = sat16(w_sum);
               idx_d      = idx_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // acc is frozen in OUT, so the argument is stable under backpressure.
   assign argument_data = (state_q == OUT) ? sat16(acc_q >>> 8) : 16'h0000;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         b_q     <= '0;
         x_q     <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         train_q <= 1'b0;
         delta_q <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         b_q     <= b_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         train_q <= train_d;
         delta_q <= delta_d;
      end
   end

endmodule

// File: tb/tb_neuron.sv
// Bench for neuron: two instances (RATE=0 and RATE=2) share all inputs; a
// transaction-level model holds both weight sets and the expected handshake
// outputs, and one compare process checks every cycle.
module tb_neuron;
   localparam int N = 4;

   logic clk, rst, train, in_valid, arg_ready, delta_valid;
   logic [8*N-1:0] in_data;
   logic [15:0] delta_data;
   logic ir0, av0, dr0, ir2, av2, dr2;
   logic [15:0] ad0, ad2;

   neuron #(.N(N), .RATE(0)) u0 (
      .clock(clk), .reset(rst), .train(train), .input_valid(in_valid),
      .input_ready(ir0), .input_data(in_data), .argument_valid(av0),
      .argument_ready(arg_ready), .argument_data(ad0), .delta_valid(delta_valid),
      .delta_ready(dr0), .delta_data(delta_data));

   neuron #(.N(N), .RATE(2)) u2 (
      .clock(clk), .reset(rst), .train(train), .input_valid(in_valid),
      .input_ready(ir2), .input_data(in_data), .argument_valid(av2),
      .argument_ready(arg_ready), .argument_data(ad2), .delta_valid(delta_valid),
      .delta_ready(dr2), .delta_data(delta_data));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;
   bit exp_ir, exp_av, exp_dr;
   logic [15:0] exp_ad0, exp_ad2;

   // Model state: index 0 is RATE=0, index 1 is RATE=2.
   int w[2][N];
   int b[2];
   int rates[2] = '{0, 2};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic logic [15:0] model_fwd(input int k, input logic [8*N-1:0] x);
      longint acc;
      acc = longint'(b[k]) * 256;
      for (int i = 0; i < N; i++) acc += longint'(w[k][i]) * longint'(x[8*i +: 8]);
      return 16'(sat(acc >>> 8));
   endfunction

   task automatic model_upd(input logic [8*N-1:0] x, input logic [15:0] d);
      longint dd;
      dd = longint'($signed(d));
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++)
            w[k][i] = sat(longint'(w[k][i]) + ((dd * longint'(x[8*i +: 8])) >>> (8 + rates[k])));
         b[k] = sat(longint'(b[k]) + (dd >>> rates[k]));
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         b[k] = 0;
         for (int i = 0; i < N; i++) w[k][i] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("input_ready0", 32'(ir0), 32'(exp_ir));
         check("argument_valid0", 32'(av0), 32'(exp_av));
         check("delta_ready0", 32'(dr0), 32'(exp_dr));
         check("input_ready2", 32'(ir2), 32'(exp_ir));
         check("argument_valid2", 32'(av2), 32'(exp_av));
         check("delta_ready2", 32'(dr2), 32'(exp_dr));
         if (exp_av) begin
            check("argument_data0", 32'(ad0), 32'(exp_ad0));
            check("argument_data2", 32'(ad2), 32'(exp_ad2));
         end
      end
   end

   task automatic garbage();
      in_valid    = 1'($urandom);
      train       = 1'($urandom);
      in_data     = $urandom;
      arg_ready   = 1'($urandom);
      delta_valid = 1'($urandom);
      delta_data  = 16'($urandom);
   endtask

   task automatic quiet();
      in_valid = 1'b0; arg_ready = 1'b0; delta_valid = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      @(posedge clk); #1;
      model_clear();
      exp_ir = 1'b1; exp_av = 1'b0; exp_dr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
   endtask

   // One full transaction starting from IDLE. abort=1 asserts reset during
   // the second weight-update cycle.
   task automatic txn(input logic [8*N-1:0] x, input bit tr, input int hold,
                      input int dwait, input logic [15:0] d, input bit abort,
                      output logic [15:0] a0, output logic [15:0] a2);
      in_valid = 1'b1; in_data = x; train = tr;
      arg_ready = 1'($urandom); delta_valid = 1'($urandom);
      @(posedge clk); #1;
      exp_ir = 1'b0; exp_av = 1'b0; exp_dr = 1'b0;
      garbage();
      repeat (N - 1) begin @(posedge clk); #1; garbage(); end
      @(posedge clk); #1;
      quiet();
      exp_ad0 = model_fwd(0, x);
      exp_ad2 = model_fwd(1, x);
      exp_av  = 1'b1;
      a0 = ad0; a2 = ad2;
      repeat (hold) begin
         @(posedge clk); #1;
         train = 1'($urandom); in_data = $urandom; delta_valid = 1'($urandom);
      end
      delta_valid = 1'b0;
      arg_ready = 1'b1;
      @(posedge clk); #1;
      arg_ready = 1'b0;
      exp_av = 1'b0;
      if (!tr) begin
         exp_ir = 1'b1;
         return;
      end
      exp_dr = 1'b1;
      repeat (dwait) begin
         @(posedge clk); #1;
         in_data = $urandom; train = 1'($urandom);
      end
      delta_valid = 1'b1; delta_data = d;
      @(posedge clk); #1;
      exp_dr = 1'b0;
      garbage();
      if (abort) begin
         @(posedge clk); #1;
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         quiet();
         model_clear();
         exp_ir = 1'b1;
         return;
      end
      model_upd(x, d);
      repeat (N) begin @(posedge clk); #1; garbage(); end
      @(posedge clk); #1;
      quiet();
      exp_ir = 1'b1;
   endtask

   logic [15:0] a0, a2, dsel;
   logic [8*N-1:0] xr;

   initial begin
      rst = 1'b0; train = 1'b0; in_data = '0; delta_data = '0;
      quiet();
      exp_ir = 1'b1; exp_av = 1'b0; exp_dr = 1'b0;
      exp_ad0 = '0; exp_ad2 = '0;
      model_clear();
      do_reset();
      check("reset_input_ready", 32'(ir0), 32'h1);
      check("reset_argument_data0", 32'(ad0), 32'h0);
      check("reset_argument_data2", 32'(ad2), 32'h0);

      // All-ones vector with zero weights and bias.
      txn(32'hffffffff, 1'b0, 0, 0, 16'h0, 1'b0, a0, a2);
      check("lit_zero_fwd0", 32'(a0), 32'h0);

      // Single training step on element 0.
      txn(32'h00000080, 1'b1, 1, 2, 16'h0100, 1'b0, a0, a2);
      check("lit_train_arg0", 32'(a0), 32'h0);
      check("model_w0_r0", 32'(w[0][0]), 32'h80);
      check("model_b_r0", 32'(b[0]), 32'h100);
      check("model_w0_r2", 32'(w[1][0]), 32'h20);
      check("model_b_r2", 32'(b[1]), 32'h40);
      txn(32'h00000080, 1'b0, 0, 0, 16'h0, 1'b0, a0, a2);
      check("lit_fwd_0140", 32'(a0), 32'h0140);
      check("lit_fwd_0050_rate2", 32'(a2), 32'h0050);

      // Positive saturation.
      do_reset();
      txn(32'hffffffff, 1'b1, 0, 0, 16'h7fff, 1'b0, a0, a2);
      check("model_w_7f7f", 32'(w[0][1]), 32'h7f7f);
      txn(32'hffffffff, 1'b1, 0, 0, 16'h7fff, 1'b0, a0, a2);
      check("model_w_sat", 32'(w[0][3]), 32'h7fff);
      check("model_b_sat", 32'(b[0]), 32'h7fff);
      txn(32'hffffffff, 1'b0, 0, 0, 16'h0, 1'b0, a0, a2);
      check("lit_fwd_7fff", 32'(a0), 32'h7fff);

      // Negative saturation.
      do_reset();
      txn(32'hffffffff, 1'b1, 0, 0, 16'h8000, 1'b0, a0, a2);
      txn(32'hffffffff, 1'b1, 0, 0, 16'h8000, 1'b0, a0, a2);
      txn(32'hffffffff, 1'b0, 0, 0, 16'h0, 1'b0, a0, a2);
      check("lit_fwd_8000", 32'(a0), 32'h8000);

      // Long backpressure on a nonzero argument.
      txn(32'h12345678, 1'b0, 10, 0, 16'h0, 1'b0, a0, a2);

      // Reset during the second update cycle discards everything.
      do_reset();
      txn(32'h01020304, 1'b1, 0, 1, 16'h0100, 1'b0, a0, a2);
      txn(32'h55aa33cc, 1'b1, 1, 0, 16'h2345, 1'b1, a0, a2);
      txn(32'($urandom), 1'b0, 0, 0, 16'h0, 1'b0, a0, a2);
      check("lit_after_abort0", 32'(a0), 32'h0);
      check("lit_after_abort2", 32'(a2), 32'h0);

      // Randomized traffic.
      for (int t = 0; t < 80; t++) begin
         if ($urandom_range(0, 19) == 0) do_reset();
         case ($urandom_range(0, 5))
            0: dsel = 16'h7fff;
            1: dsel = 16'h8000;
            default: dsel = 16'($urandom);
         endcase
         xr = $urandom;
         if ($urandom_range(0, 3) == 0) xr = 32'hffffffff;
         txn(xr, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             dsel, ($urandom_range(0, 15) == 0), a0, a2);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
